// File: rtl/sec_array_tdma_ctrl_if.sv
// Requester-side bus of the shared secure register array.
// The requester (L or H pipeline stage) is the master; the controller is the slave.
interface sec_array_tdma_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/sec_array_tdma_ctrl.sv
// Time-division controller sharing one labelled register array between a
// public (L) and a secret (H) requester. Slots alternate L, H, L, H at a
// fixed rate, so when L is granted never depends on anything H does.
// Each entry carries a label bit (0 = L, 1 = H): L cannot read H entries,
// H cannot write L entries, and lowering a label scrubs the entry's data.
module sec_array_tdma_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter int SLOT_LEN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sec_array_tdma_ctrl_if.slave l_bus,
  sec_array_tdma_ctrl_if.slave h_bus,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_idx,
  input  logic                 cfg_lbl,
  output logic                 slot_h
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(SLOT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

  typedef enum logic {
    SLOT_L = 1'b0,
    SLOT_H = 1'b1
  } slot_t;

  slot_t             slot_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  lbl_q;

  logic              l_rvalid_q;
  logic [DATA_W-1:0] l_rdata_q;
  logic              l_rerr_q;
  logic              h_rvalid_q;
  logic [DATA_W-1:0] h_rdata_q;

  logic              slot_first;
  logic              l_take;
  logic              h_take;
  logic              l_deny;
  logic              h_deny;
  logic              l_rd;
  logic              h_rd;
  logic              l_wr;
  logic              h_wr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DEPTH-1:0]  scrub;

  // Free-running slot schedule: counter wraps every SLOT_LEN cycles and the owner flips on each wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      slot_q <= SLOT_L;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      slot_q <= (slot_q == SLOT_L) ? SLOT_H : SLOT_L;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign slot_h     = (slot_q == SLOT_H);
  assign slot_first = (cnt_q == '0);

  // Only the slot owner can be granted, only in the first cycle, and an idle slot is never lent out.
  assign l_take = slot_first & (slot_q == SLOT_L) & l_bus.req;
  assign h_take = slot_first & (slot_q == SLOT_H) & h_bus.req;

  // Access rules are judged against the label as it stands before the edge.
  assign l_deny = lbl_q[l_bus.addr];
  assign h_deny = ~lbl_q[h_bus.addr];

  assign l_rd = l_take & ~l_bus.we;
  assign h_rd = h_take & ~h_bus.we;
  assign l_wr = l_take & l_bus.we;
  assign h_wr = h_take & h_bus.we & ~h_deny;

  // At most one side owns a slot, so a single write port serves both requesters.
  always_comb begin
    wr_en   = l_wr | h_wr;
    wr_addr = l_wr ? l_bus.addr  : h_bus.addr;
    wr_data = l_wr ? l_bus.wdata : h_bus.wdata;
  end

  // A label moving from H down to L marks that entry for scrubbing.
  always_comb begin
    scrub = '0;
    if (cfg_we && lbl_q[cfg_idx] && !cfg_lbl) begin
      scrub[cfg_idx] = 1'b1;
    end
  end

  // Array storage and labels; a scrub beats a same-edge write so secret data never leaks downward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      lbl_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (scrub[i]) begin
          mem_q[i] <= '0;
        end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
          mem_q[i] <= wr_data;
        end
      end
      if (cfg_we) begin
        lbl_q[cfg_idx] <= cfg_lbl;
      end
    end
  end

  // L read return: one cycle after grant, zero data plus error when the entry is secret.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_rvalid_q <= 1'b0;
      l_rdata_q  <= '0;
      l_rerr_q   <= 1'b0;
    end else begin
      l_rvalid_q <= l_rd;
      l_rerr_q   <= l_rd & l_deny;
      l_rdata_q  <= (l_rd && !l_deny) ? mem_q[l_bus.addr] : '0;
    end
  end

  // H read return: H may read every entry, so it never errors on reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_rvalid_q <= 1'b0;
      h_rdata_q  <= '0;
    end else begin
      h_rvalid_q <= h_rd;
      h_rdata_q  <= h_rd ? mem_q[h_bus.addr] : '0;
    end
  end

  // Grants and write errors are combinational pulses; holding them low in reset keeps outputs quiet.
  assign l_bus.gnt    = l_take & reset;
  assign l_bus.rvalid = l_rvalid_q;
  assign l_bus.rdata  = l_rdata_q;
  assign l_bus.err    = l_rerr_q;

  assign h_bus.gnt    = h_take & reset;
  assign h_bus.rvalid = h_rvalid_q;
  assign h_bus.rdata  = h_rdata_q;
  assign h_bus.err    = h_take & h_bus.we & h_deny & reset;

endmodule
